// File: rtl/rvfi_bus_fairness_if.sv
// Per-channel cmd/rsp bus bundle watched by the fairness monitor.
interface rvfi_bus_fairness_if #(
    parameter int unsigned NCH = 2
) ();
    logic [NCH-1:0] cmd_valid;
    logic [NCH-1:0] cmd_ready;
    logic [NCH-1:0] cmd_wr;
    logic [NCH-1:0] rsp_valid;

    modport master (output cmd_valid, output cmd_wr, input cmd_ready, input rsp_valid);
    modport slave (input cmd_valid, input cmd_wr, output cmd_ready, output rsp_valid);
    // Passive observer: sees every bus signal, drives none.
    modport monitor (input cmd_valid, input cmd_ready, input cmd_wr, input rsp_valid);
endinterface

// File: rtl/rvfi_bus_fairness.sv
// Bus fairness monitor: flags cmd stalls, late responses and protocol
// violations per channel, and combines them into a single 'fair' flag.
module rvfi_bus_fairness #(
    parameter int unsigned   NCH     = 2,
    parameter int unsigned   CMD_MAX = 4,
    parameter int unsigned   RSP_MAX = 4,
    parameter int unsigned   MAX_OUT = 1,
    parameter logic [NCH-1:0] WR_RSP = '0
) (
    input  logic                     clock,
    input  logic                     resetn,
    rvfi_bus_fairness_if.monitor     bus,
    input  logic                     trap,
    output logic                     fair,
    output logic [NCH-1:0]           cmd_stall_err,
    output logic [NCH-1:0]           rsp_stall_err,
    output logic [NCH-1:0]           proto_err,
    output logic                     first_err_valid,
    output logic [2:0]               first_err_chan
);
    localparam int unsigned     MaxLim = (CMD_MAX > RSP_MAX) ? CMD_MAX : RSP_MAX;
    localparam int unsigned     CW     = $clog2(MaxLim + 1);
    localparam int unsigned     OW     = 4;
    localparam logic [CW-1:0]   CntSat = '1;
    localparam logic [CW-1:0]   CmdLim = CW'(CMD_MAX);
    localparam logic [CW-1:0]   RspLim = CW'(RSP_MAX);
    localparam logic [OW-1:0]   OutLim = OW'(MAX_OUT);

    logic [CW-1:0]  cmd_wait_q [NCH];
    logic [CW-1:0]  cmd_wait_d [NCH];
    logic [CW-1:0]  rsp_wait_q [NCH];
    logic [CW-1:0]  rsp_wait_d [NCH];
    logic [OW-1:0]  out_cnt_q  [NCH];
    logic [OW-1:0]  out_cnt_d  [NCH];
    logic [NCH-1:0] proto_q, proto_d;
    logic           first_valid_q, first_valid_d;
    logic [2:0]     first_chan_q, first_chan_d;

    logic [NCH-1:0] accept;
    logic [NCH-1:0] expects_rsp;
    logic [NCH-1:0] rsp_hit;
    logic [NCH-1:0] spurious;
    logic [NCH-1:0] overflow;
    logic [NCH-1:0] new_err;

    assign accept      = bus.cmd_valid & bus.cmd_ready;
    assign expects_rsp = accept & (~bus.cmd_wr | WR_RSP);
    assign new_err     = spurious | overflow;

    // Per-channel counter next-state and violation detection.
    always_comb begin
        rsp_hit  = '0;
        spurious = '0;
        overflow = '0;
        for (int c = 0; c < NCH; c++) begin
            cmd_wait_d[c] = '0;
            rsp_wait_d[c] = '0;
            out_cnt_d[c]  = out_cnt_q[c];

            if (bus.cmd_valid[c] && !bus.cmd_ready[c]) begin
                cmd_wait_d[c] = (cmd_wait_q[c] == CntSat) ? cmd_wait_q[c]
                                                          : cmd_wait_q[c] + 1'b1;
            end

            rsp_hit[c]  = bus.rsp_valid[c] && (out_cnt_q[c] != '0);
            spurious[c] = bus.rsp_valid[c] && (out_cnt_q[c] == '0);
            overflow[c] = expects_rsp[c] && (out_cnt_q[c] == OutLim) && !bus.rsp_valid[c];

            // A response only retires an earlier accept, never a same-cycle one.
            if (overflow[c]) begin
                out_cnt_d[c] = out_cnt_q[c];
            end else if (expects_rsp[c] && !rsp_hit[c]) begin
                out_cnt_d[c] = out_cnt_q[c] + 1'b1;
            end else if (!expects_rsp[c] && rsp_hit[c]) begin
                out_cnt_d[c] = out_cnt_q[c] - 1'b1;
            end

            if ((out_cnt_q[c] != '0) && !bus.rsp_valid[c]) begin
                rsp_wait_d[c] = (rsp_wait_q[c] == CntSat) ? rsp_wait_q[c]
                                                          : rsp_wait_q[c] + 1'b1;
            end
        end
    end

    // Sticky error bits; first erroring cycle latches its lowest channel index.
    always_comb begin
        proto_d       = proto_q | new_err;
        first_valid_d = first_valid_q;
        first_chan_d  = first_chan_q;
        if (!first_valid_q && (new_err != '0)) begin
            first_valid_d = 1'b1;
            for (int c = NCH - 1; c >= 0; c--) begin
                if (new_err[c]) begin
                    first_chan_d = 3'(c);
                end
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int c = 0; c < NCH; c++) begin
                cmd_wait_q[c] <= '0;
                rsp_wait_q[c] <= '0;
                out_cnt_q[c]  <= '0;
            end
            proto_q       <= '0;
            first_valid_q <= 1'b0;
            first_chan_q  <= 3'd0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                cmd_wait_q[c] <= cmd_wait_d[c];
                rsp_wait_q[c] <= rsp_wait_d[c];
                out_cnt_q[c]  <= out_cnt_d[c];
            end
            proto_q       <= proto_d;
            first_valid_q <= first_valid_d;
            first_chan_q  <= first_chan_d;
        end
    end

    // Outputs decoded from registered state; trap gates fair immediately.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            cmd_stall_err[c] = (cmd_wait_q[c] >= CmdLim);
            rsp_stall_err[c] = (rsp_wait_q[c] >= RspLim);
        end
        proto_err       = proto_q;
        first_err_valid = first_valid_q;
        first_err_chan  = first_chan_q;
        fair            = !trap && (cmd_stall_err == '0) && (rsp_stall_err == '0)
                          && (proto_q == '0);
    end
endmodule

// File: tb/tb_rvfi_bus_fairness.sv
// Directed bench for rvfi_bus_fairness with default parameters
// (NCH=2, CMD_MAX=4, RSP_MAX=4, MAX_OUT=1, WR_RSP=0).
module tb_rvfi_bus_fairness;
    logic       clock;
    logic       resetn;
    logic       trap;
    logic       fair;
    logic [1:0] cmd_stall_err;
    logic [1:0] rsp_stall_err;
    logic [1:0] proto_err;
    logic       first_err_valid;
    logic [2:0] first_err_chan;

    int checks   = 0;
    int failures = 0;

    rvfi_bus_fairness_if #(.NCH(2)) bus_if ();

    rvfi_bus_fairness dut (
        .clock           (clock),
        .resetn          (resetn),
        .bus             (bus_if),
        .trap            (trap),
        .fair            (fair),
        .cmd_stall_err   (cmd_stall_err),
        .rsp_stall_err   (rsp_stall_err),
        .proto_err       (proto_err),
        .first_err_valid (first_err_valid),
        .first_err_chan  (first_err_chan)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_fair, input logic [1:0] e_cmd,
                             input logic [1:0] e_rsp, input logic [1:0] e_proto,
                             input logic e_fev, input logic [2:0] e_fec);
        check_eq({tag, ".fair"},  8'(fair),            8'(e_fair));
        check_eq({tag, ".cmd"},   8'(cmd_stall_err),   8'(e_cmd));
        check_eq({tag, ".rsp"},   8'(rsp_stall_err),   8'(e_rsp));
        check_eq({tag, ".proto"}, 8'(proto_err),       8'(e_proto));
        check_eq({tag, ".fev"},   8'(first_err_valid), 8'(e_fev));
        check_eq({tag, ".fec"},   8'(first_err_chan),  8'(e_fec));
    endtask

    // Advance one clock and settle past the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_idle();
        bus_if.cmd_valid = 2'b00;
        bus_if.cmd_ready = 2'b00;
        bus_if.cmd_wr    = 2'b00;
        bus_if.rsp_valid = 2'b00;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        step();
    endtask

    initial begin
        bus_idle();
        trap   = 1'b0;
        resetn = 1'b0;
        #3;
        check_all("rst", 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0);
        trap = 1'b1;
        #1;
        check_eq("rst_trap.fair", 8'(fair), 8'd0);
        trap = 1'b0;
        step();
        step();
        resetn = 1'b1;
        step();
        check_all("idle", 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0);

        // cmd stall on ch0 (a write, so the final accept expects no response)
        bus_if.cmd_valid = 2'b01;
        bus_if.cmd_wr    = 2'b01;
        repeat (3) step();
        check_all("stall3", 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0);
        step();
        check_all("stall4", 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 3'd0);
        repeat (6) step();
        check_all("stall_sat", 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 3'd0);
        bus_if.cmd_ready = 2'b01;
        step();
        bus_idle();
        check_all("stall_rel", 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0);

        // ch1 read answered on the 3rd cycle after accept
        bus_if.cmd_valid = 2'b10;
        bus_if.cmd_ready = 2'b10;
        step();
        bus_idle();
        check_all("rd_acc", 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0);
        step();
        step();
        check_all("rd_w2", 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0);
        bus_if.rsp_valid = 2'b10;
        step();
        bus_idle();
        check_all("rd_rsp", 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0);

        // ch1 response wait limit; a leftover count would overflow here instead
        bus_if.cmd_valid = 2'b10;
        bus_if.cmd_ready = 2'b10;
        step();
        bus_idle();
        repeat (3) step();
        check_all("rw3", 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0);
        step();
        check_all("rw4", 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 3'd0);
        bus_if.rsp_valid = 2'b10;
        step();
        bus_idle();
        check_all("rw_clr", 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0);

        // single-cycle trap
        trap = 1'b1;
        #1;
        check_eq("trap.fair", 8'(fair), 8'd0);
        step();
        trap = 1'b0;
        #1;
        check_eq("trap_off.fair", 8'(fair), 8'd1);

        // ch1 outstanding overflow with MAX_OUT=1
        bus_if.cmd_valid = 2'b10;
        bus_if.cmd_ready = 2'b10;
        step();
        check_all("ov1", 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0);
        step();
        bus_idle();
        check_all("ov2", 1'b0, 2'b00, 2'b00, 2'b10, 1'b1, 3'd1);
        bus_if.rsp_valid = 2'b01;
        step();
        bus_idle();
        check_all("ov_ch0", 1'b0, 2'b00, 2'b00, 2'b11, 1'b1, 3'd1);
        // count held at 1, so ch1 keeps waiting: wait reaches 4 two edges later
        step();
        step();
        check_all("ov_hold", 1'b0, 2'b00, 2'b10, 2'b11, 1'b1, 3'd1);

        // reset with a ch0 read outstanding and a ch0 stall in progress
        do_reset();
        bus_if.cmd_valid = 2'b01;
        bus_if.cmd_ready = 2'b01;
        step();
        bus_if.cmd_ready = 2'b00;
        bus_if.cmd_wr    = 2'b01;
        repeat (4) step();
        check_eq("pre_rst.cmd", 8'(cmd_stall_err), 8'h01);
        resetn = 1'b0;
        #1;
        check_all("rst_mid", 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0);
        bus_idle();
        step();
        step();
        resetn = 1'b1;
        bus_if.rsp_valid = 2'b01;
        step();
        bus_idle();
        check_all("post_rst_spur", 1'b0, 2'b00, 2'b00, 2'b01, 1'b1, 3'd0);

        // write on ch0 with WR_RSP=0 followed by a response
        do_reset();
        check_all("rst2", 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0);
        bus_if.cmd_valid = 2'b01;
        bus_if.cmd_ready = 2'b01;
        bus_if.cmd_wr    = 2'b01;
        step();
        bus_idle();
        check_eq("wr_acc.fair", 8'(fair), 8'd1);
        bus_if.rsp_valid = 2'b01;
        step();
        bus_idle();
        check_all("wr_spur", 1'b0, 2'b00, 2'b00, 2'b01, 1'b1, 3'd0);
        repeat (3) step();
        check_all("wr_sticky", 1'b0, 2'b00, 2'b00, 2'b01, 1'b1, 3'd0);

        // simultaneous errors on ch0 and ch1, then a later ch1 error
        do_reset();
        bus_if.rsp_valid = 2'b11;
        step();
        bus_idle();
        check_all("sim_err", 1'b0, 2'b00, 2'b00, 2'b11, 1'b1, 3'd0);
        bus_if.rsp_valid = 2'b10;
        step();
        bus_idle();
        check_eq("late_err.fec", 8'(first_err_chan), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rvfi_bus_fairness.md
RVFI_BUS_FAIRNESS -- requirements
Module: rvfi_bus_fairness

Interface
REQ-001 SHALL have parameter NCH, default 2, number of monitored cmd/rsp bus channels (1..8).
REQ-002 SHALL have parameter CMD_MAX, default 4, max consecutive cycles a cmd may stall (valid && !ready).
REQ-003 SHALL have parameter RSP_MAX, default 4, max consecutive cycles an outstanding read may wait for rsp.
REQ-004 SHALL have parameter MAX_OUT, default 1, max outstanding responses per channel (1..15).
REQ-005 SHALL have parameter WR_RSP, default 0, per-channel NCH-bit mask; bit c=1 means writes on channel c also return a response.
REQ-006 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have port cmd_valid  input  NCH  per-channel command valid.
REQ-009 SHALL have port cmd_ready  input  NCH  per-channel command ready.
REQ-010 SHALL have port cmd_wr  input  NCH  per-channel command is a write.
REQ-011 SHALL have port rsp_valid  input  NCH  per-channel response valid (no back-pressure).
REQ-012 SHALL have port trap  input  1  core trap indication (rvfi_trap).
REQ-013 SHALL have port fair  output  1  environment-is-fair flag, for use in restrict/assume.
REQ-014 SHALL have port cmd_stall_err  output  NCH  cmd stall limit reached.
REQ-015 SHALL have port rsp_stall_err  output  NCH  rsp wait limit reached.
REQ-016 SHALL have port proto_err  output  NCH  sticky: spurious response or outstanding overflow.
REQ-017 SHALL have port first_err_valid  output  1  sticky: some proto_err bit has been set.
REQ-018 SHALL have port first_err_chan  output  3  index of first channel to raise proto_err.

Function
REQ-019 Counter width CW = clog2(max(CMD_MAX,RSP_MAX)+1); all counters SHALL saturate at 2^CW-1, never wrap.
REQ-020 cmd_wait[c] SHALL increment when cmd_valid[c] && !cmd_ready[c], else clear to 0 next cycle.
REQ-021 Accept on c = cmd_valid[c] && cmd_ready[c]; expects_rsp = accept && (!cmd_wr[c] || WR_RSP[c]).
REQ-022 out_cnt[c] next = out_cnt + expects_rsp - (rsp_valid[c] && out_cnt>0); simultaneous accept and rsp SHALL leave count unchanged.
REQ-023 A response SHALL retire only an earlier accept; rsp_valid[c] while out_cnt[c]==0 SHALL set proto_err[c] (spurious); count stays 0.
REQ-024 expects_rsp while out_cnt[c]==MAX_OUT and no rsp_valid[c] SHALL set proto_err[c] (overflow); count holds at MAX_OUT.
REQ-025 rsp_wait[c] SHALL increment when out_cnt[c]>0 && !rsp_valid[c]; clear to 0 on rsp_valid[c] or when out_cnt[c]==0.
REQ-026 cmd_stall_err[c] = (cmd_wait[c] >= CMD_MAX); rsp_stall_err[c] = (rsp_wait[c] >= RSP_MAX); combinational from registers.
REQ-027 fair = !trap && no cmd_stall_err && no rsp_stall_err && no proto_err; combinational, same-cycle on trap.
REQ-028 proto_err bits SHALL be sticky until reset.
REQ-029 first_err_chan SHALL capture lowest-index channel among those raising proto_err in the first erroring cycle; later errors SHALL NOT change it.
REQ-030 Channels SHALL be fully independent; no cross-channel coupling except first_err arbitration.

Reset
REQ-031 resetn low SHALL asynchronously clear all counters, proto_err, first_err_valid, first_err_chan to 0.
REQ-032 During and right after reset, outputs SHALL be fair=!trap, all err vectors 0.
REQ-033 Reset mid-transaction SHALL discard outstanding state; a rsp_valid in the first cycle after release SHALL flag spurious.

Verification
REQ-034 ch0 cmd_valid=1, cmd_ready=0 for 4 cycles -> cmd_stall_err[0]=1 and fair=0 after 4th edge; ready=1 -> both clear next edge.
REQ-035 ch1 read accepted, rsp_valid at 3rd cycle after -> rsp_wait peaks 2, fair stays 1, out_cnt[1] returns 0.
REQ-036 ch0 write accepted, WR_RSP=0, then rsp_valid[0] -> proto_err[0]=1, first_err_chan=0, fair=0 until reset.
REQ-037 MAX_OUT=1: two reads accepted on ch1 with no rsp -> proto_err[1]=1 on second accept edge; out_cnt[1] stays 1.
REQ-038 Simultaneous proto_err on ch0 and ch1 same cycle -> first_err_chan=0; later ch1 error leaves it 0.
REQ-039 trap=1 single cycle with counters idle -> fair=0 that cycle only; resetn pulse low mid-stall -> all errors 0 immediately.
